// File: rtl/bitwise_logic_pipe_if.sv
// +----------------------------------------------------------------------+
// | bitwise_logic_pipe_if : operand/result handshake bundle               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface bitwise_logic_pipe_if #(
  parameter int N     = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out;
  logic             out_zero;
  logic             out_ones;
  logic [CNT_W-1:0] txn_cnt;
`ifdef BITOP_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, out_zero, out_ones, txn_cnt
`ifdef BITOP_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, out_zero, out_ones, txn_cnt
`ifdef BITOP_PARITY_EN
    , output out_parity
`endif
  );
endinterface

`default_nettype wire

// File: rtl/bitwise_logic_pipe.sv
// +----------------------------------------------------------------------+
// | bitwise_logic_pipe : 2-stage valid/ready N-bit bitwise logic unit     |
// | Optional macro BITOP_PARITY_EN adds registered out_parity.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bitwise_logic_pipe #(
  parameter int N     = 5,
  parameter int CNT_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  bitwise_logic_pipe_if.slave bus
);
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;

  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_a_q, s1_a_d;
  logic [N-1:0]     s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_q, out_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_ready;
  logic             accept;
  logic             out_hs;
  logic [N-1:0]     res;

  always_comb begin
    s2_adv   = !out_valid_q || bus.out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    // Hold off the producer while reset is asserted.
    in_ready = !rst && s1_adv;
    accept   = bus.in_valid && in_ready;
    out_hs   = out_valid_q && bus.out_ready;
  end

  always_comb begin
    case (s1_op_q)
      OP_AND:  res = s1_a_q & s1_b_q;
      OP_OR:   res = s1_a_q | s1_b_q;
      OP_XOR:  res = s1_a_q ^ s1_b_q;
      OP_NAND: res = ~(s1_a_q & s1_b_q);
      OP_NOR:  res = ~(s1_a_q | s1_b_q);
      OP_XNOR: res = ~(s1_a_q ^ s1_b_q);
      OP_ANDN: res = s1_a_q & ~s1_b_q;
      default: res = s1_a_q;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    txn_cnt_d   = txn_cnt_q;
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d  = bus.a;
        s1_b_d  = bus.b;
        s1_op_d = bus.op;
      end
    end
    // An empty S1 moving forward clears S2 so flags read 0 when idle.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      out_d       = s1_valid_q ? res : '0;
      zero_d      = s1_valid_q && (res == '0);
      ones_d      = s1_valid_q && (res == '1);
    end
    if (out_hs) begin
      txn_cnt_d = txn_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      txn_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

`ifdef BITOP_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (s2_adv) begin
      parity_d = s1_valid_q && (^res);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign bus.out_parity = parity_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_ones  = ones_q;
  assign bus.txn_cnt   = txn_cnt_q;

endmodule

`default_nettype wire
